prog_loader: RTL

//  Upstream boot stage for the single-cycle cpu. Accepts a stream of 32-bit program words
//  (text and data regions) over a valid/ready port and writes them into the unified system

---
 rtl/prog_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: boot-stage loader for the single-cycle cpu.
// Streams program words into unified memory (text from word 0, data from
// DATA_BASE), then enables the cpu for a fixed cycle budget and flags done.
module prog_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_BASE  = 2048,
    parameter int RUN_CYCLES = 3000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    input  logic                  in_region,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] text_count,
    output logic [ADDR_WIDTH-1:0] data_count
);

    // Budget counter needs to hold RUN_CYCLES itself; keep at least one bit.
    localparam int CNT_W = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;

    // Text region ends where the data region begins.
    localparam logic [ADDR_WIDTH-1:0] TEXT_END   = ADDR_WIDTH'(DATA_BASE);
    // Data pointer carries one extra bit so "last word written" is visible
    // as the MSB instead of a wrap back to zero.
    localparam logic [ADDR_WIDTH:0]   DATA_START = (ADDR_WIDTH + 1)'(DATA_BASE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t                  state_reg;
    logic                    in_ready_reg;
    logic                    mem_we_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic [31:0]             mem_wdata_reg;
    logic                    cpu_run_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [ADDR_WIDTH-1:0]   text_ptr_reg;
    logic [ADDR_WIDTH:0]     data_ptr_reg;
    logic [ADDR_WIDTH-1:0]   text_count_reg;
    logic [ADDR_WIDTH-1:0]   data_count_reg;
    logic [CNT_W-1:0]        cycle_cnt_reg;

    logic handshake;
    logic text_full;
    logic data_full;
    logic word_fits;

    // Acceptance and region-overflow decode for the word on the input port.
    assign handshake = in_valid & in_ready_reg;
    assign text_full = (text_ptr_reg == TEXT_END);
    assign data_full = data_ptr_reg[ADDR_WIDTH];
    assign word_fits = in_region ? ~data_full : ~text_full;

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            cpu_run_reg    <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            text_ptr_reg   <= '0;
            data_ptr_reg   <= '0;
            text_count_reg <= '0;
            data_count_reg <= '0;
            cycle_cnt_reg  <= '0;
        end else begin
            // Write strobe is a single-cycle echo of an accepted, in-range word.
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE, HALT: begin
                    if (start) begin
                        state_reg      <= LOAD;
                        in_ready_reg   <= 1'b1;
                        text_ptr_reg   <= '0;
                        data_ptr_reg   <= DATA_START;
                        text_count_reg <= '0;
                        data_count_reg <= '0;
                        err_reg        <= 1'b0;
                        done_reg       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (word_fits) begin
                            mem_we_reg    <= 1'b1;
                            mem_wdata_reg <= in_data;
                            if (in_region) begin
                                mem_addr_reg   <= data_ptr_reg[ADDR_WIDTH-1:0];
                                data_ptr_reg   <= data_ptr_reg + (ADDR_WIDTH + 1)'(1);
                                data_count_reg <= data_count_reg + ADDR_WIDTH'(1);
                            end else begin
                                mem_addr_reg   <= text_ptr_reg;
                                text_ptr_reg   <= text_ptr_reg + ADDR_WIDTH'(1);
                                text_count_reg <= text_count_reg + ADDR_WIDTH'(1);
                            end
                        end else begin
                            // Overflowing word is dropped; pointer holds, stream keeps draining.
                            err_reg <= 1'b1;
                        end
                        if (in_last) begin
                            state_reg    <= DRAIN;
                            in_ready_reg <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (RUN_CYCLES == 0) begin
                        state_reg <= HALT;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg     <= RUN;
                        cpu_run_reg   <= 1'b1;
                        cycle_cnt_reg <= CNT_W'(RUN_CYCLES);
                    end
                end
                RUN: begin
                    if (cycle_cnt_reg == CNT_W'(1)) begin
                        state_reg   <= HALT;
                        cpu_run_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b0;
                    cpu_run_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign cpu_run    = cpu_run_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign text_count = text_count_reg;
    assign data_count = data_count_reg;

endmodule
